hbm_nch_pd_model: RTL and testbench

// Parametrised N-channel HBM latency/storage model for FlooNoC test nodes.
// - Sits behind a narrow/wide join, on a simplified valid/ready memory port.
// - Interleaves requests across NumChannels independent channels.
// - Each channel: fixed minimum latency, bounded outstanding count, in-order completion.
// - Responses from all channels are merged by a round-robin arbiter.

---
 rtl/hbm_nch_pd_model_if.sv | 32 +++
 rtl/hbm_nch_pd_model.sv | 144 ++++++++++++++
 tb/tb_hbm_nch_pd_model.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hbm_nch_pd_model_if.sv
// Request/response port of the N-channel HBM latency model.
// A beat moves on a rising clk edge where valid and ready are both high; the producer
// holds valid and payload stable until that edge, and ready may depend on the payload.
interface hbm_nch_pd_model_if #(
    parameter int AddrWidth = 48,
    parameter int DataWidth = 512,
    parameter int IdWidth   = 4,
    parameter int ChanWidth = 2
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic                 req_write_i;
    logic [AddrWidth-1:0] req_addr_i;
    logic [DataWidth-1:0] req_wdata_i;
    logic [IdWidth-1:0]   req_id_i;
    logic                 rsp_valid_o;
    logic                 rsp_ready_i;
    logic                 rsp_write_o;
    logic [IdWidth-1:0]   rsp_id_o;
    logic [DataWidth-1:0] rsp_rdata_o;
    logic [ChanWidth-1:0] rsp_chan_o;

    modport master (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_id_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_write_o, rsp_id_o, rsp_rdata_o, rsp_chan_o
    );

    modport slave (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, req_id_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_write_o, rsp_id_o, rsp_rdata_o, rsp_chan_o
    );
endinterface

// File: rtl/hbm_nch_pd_model.sv
// N-channel HBM latency/storage model: address-interleaved channels, each with a
// fixed-latency in-order FIFO, merged through a round-robin response arbiter.
module hbm_nch_pd_model #(
    parameter int NumChannels    = 4,
    parameter int AddrWidth      = 48,
    parameter int DataWidth      = 512,
    parameter int IdWidth        = 4,
    parameter int Latency        = 16,
    parameter int MaxOutstanding = 8,
    parameter int InterleaveLsb  = 12,
    parameter int MemDepth       = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    hbm_nch_pd_model_if.slave bus,
    output logic              busy_o
);
    localparam int CW   = (NumChannels > 1) ? $clog2(NumChannels) : 0;
    localparam int CWW  = (CW > 0) ? CW : 1;
    localparam int OffW = $clog2(DataWidth / 8);
    localparam int LowW = InterleaveLsb - OffW;
    localparam int MW   = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam int PW   = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int NW   = $clog2(MaxOutstanding + 1);
    localparam int AW   = $clog2(Latency + 1);
    localparam logic [AddrWidth-1:0] LowMask = (AddrWidth'(1) << InterleaveLsb) - AddrWidth'(1);
    localparam logic [AW-1:0]        AgeMax  = AW'(Latency);
    localparam logic [NW-1:0]        CntMax  = NW'(MaxOutstanding);

    logic [DataWidth-1:0] mem_q      [NumChannels][MemDepth];
    logic                 fifo_write [NumChannels][MaxOutstanding];
    logic [IdWidth-1:0]   fifo_id    [NumChannels][MaxOutstanding];
    logic [DataWidth-1:0] fifo_data  [NumChannels][MaxOutstanding];
    logic [AW-1:0]        fifo_age   [NumChannels][MaxOutstanding];
    logic [PW-1:0]        wr_ptr     [NumChannels];
    logic [PW-1:0]        rd_ptr     [NumChannels];
    logic [NW-1:0]        count      [NumChannels];

    logic [AddrWidth-1:0]   addr_hi, addr_lo, word_full;
    logic [CWW-1:0]         req_chan;
    logic [MW-1:0]          req_word;
    logic                   req_ready, accept;
    logic [NumChannels-1:0] eligible, push_vec, pop_vec;
    logic [CWW-1:0]         rr_ptr, pick, grant, lock_chan;
    logic                   found, lock_valid, rsp_valid, pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Channel field is cut out of the address; the remaining word bits are packed and folded.
    always_comb begin
        addr_hi   = bus.req_addr_i >> (InterleaveLsb + CW);
        addr_lo   = (bus.req_addr_i & LowMask) >> OffW;
        word_full = (addr_hi << LowW) | addr_lo;
        req_word  = MW'(word_full % AddrWidth'(MemDepth));
        req_chan  = CWW'(bus.req_addr_i >> InterleaveLsb) & CWW'(NumChannels - 1);
        req_ready = !rst_i && (count[req_chan] < CntMax);
        accept    = bus.req_valid_i && req_ready;
    end

    // A stalled grant is locked so later-eligible channels cannot change the presented response.
    always_comb begin
        eligible = '0;
        for (int c = 0; c < NumChannels; c++)
            eligible[c] = (count[c] != '0) && (fifo_age[c][rd_ptr[c]] == AgeMax);
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NumChannels; i++) begin
            if (!found && eligible[(int'(rr_ptr) + i) % NumChannels]) begin
                found = 1'b1;
                pick  = CWW'((int'(rr_ptr) + i) % NumChannels);
            end
        end
        grant     = lock_valid ? lock_chan : pick;
        rsp_valid = lock_valid || found;
        pop       = rsp_valid && bus.rsp_ready_i;
        push_vec  = '0;
        pop_vec   = '0;
        busy_o    = 1'b0;
        for (int c = 0; c < NumChannels; c++) begin
            push_vec[c] = accept && (req_chan == CWW'(c));
            pop_vec[c]  = pop && (grant == CWW'(c));
            busy_o      = busy_o | (count[c] != '0);
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = rsp_valid;
    assign bus.rsp_write_o = rsp_valid && fifo_write[grant][rd_ptr[grant]];
    assign bus.rsp_id_o    = rsp_valid ? fifo_id[grant][rd_ptr[grant]] : '0;
    assign bus.rsp_rdata_o = rsp_valid ? fifo_data[grant][rd_ptr[grant]] : '0;
    assign bus.rsp_chan_o  = rsp_valid ? grant : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NumChannels; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
                for (int e = 0; e < MaxOutstanding; e++) begin
                    fifo_write[c][e] <= 1'b0;
                    fifo_id[c][e]    <= '0;
                    fifo_data[c][e]  <= '0;
                    fifo_age[c][e]   <= '0;
                end
                for (int w = 0; w < MemDepth; w++)
                    mem_q[c][w] <= '0;
            end
            rr_ptr     <= '0;
            lock_valid <= 1'b0;
            lock_chan  <= '0;
        end else begin
            for (int c = 0; c < NumChannels; c++) begin
                for (int e = 0; e < MaxOutstanding; e++)
                    if (fifo_age[c][e] != AgeMax)
                        fifo_age[c][e] <= fifo_age[c][e] + 1'b1;
                // Read data is captured at accept, so the FIFO carries the response payload.
                if (push_vec[c]) begin
                    fifo_write[c][wr_ptr[c]] <= bus.req_write_i;
                    fifo_id[c][wr_ptr[c]]    <= bus.req_id_i;
                    fifo_data[c][wr_ptr[c]]  <= bus.req_write_i ? '0 : mem_q[c][req_word];
                    fifo_age[c][wr_ptr[c]]   <= '0;
                    wr_ptr[c]                <= next_ptr(wr_ptr[c]);
                    if (bus.req_write_i)
                        mem_q[c][req_word] <= bus.req_wdata_i;
                end
                if (pop_vec[c])
                    rd_ptr[c] <= next_ptr(rd_ptr[c]);
                if (push_vec[c] && !pop_vec[c])
                    count[c] <= count[c] + 1'b1;
                else if (!push_vec[c] && pop_vec[c])
                    count[c] <= count[c] - 1'b1;
            end
            if (pop) begin
                rr_ptr     <= (grant == CWW'(NumChannels - 1)) ? '0 : grant + 1'b1;
                lock_valid <= 1'b0;
            end else if (rsp_valid) begin
                lock_valid <= 1'b1;
                lock_chan  <= grant;
            end
        end
    end
endmodule

// File: tb/tb_hbm_nch_pd_model.sv
// Bench for hbm_nch_pd_model: drives requests, predicts each response into a queue,
// and matches responses per channel in order.
module tb_hbm_nch_pd_model;
    localparam int NC = 4;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam int IW = 4;
    localparam int LAT = 16;
    localparam int MO = 8;
    localparam int IL = 12;
    localparam int MD = 16;
    localparam int EW = 2 + 1 + IW + DW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_rsp = 0;
    int   mon_idx;
    bit   stalled = 1'b0;
    logic [EW-1:0] held, obs;
    logic [EW-1:0] exp_q[$];
    logic [1:0]    grant_log[$];
    logic [DW-1:0] model_mem [NC][MD];

    hbm_nch_pd_model_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .ChanWidth(2)) bus_if ();

    hbm_nch_pd_model #(
        .NumChannels(NC), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .Latency(LAT),
        .MaxOutstanding(MO), .InterleaveLsb(IL), .MemDepth(MD)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if),
        .busy_o(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] chan_of(input logic [AW-1:0] a);
        return a[13:12];
    endfunction

    function automatic logic [3:0] word_of(input logic [AW-1:0] a);
        logic [AW-1:0] w;
        w = ((a >> 14) << 9) | ((a & 48'hfff) >> 3);
        return w[3:0];
    endfunction

    function automatic void clear_model();
        for (int c = 0; c < NC; c++)
            for (int w = 0; w < MD; w++)
                model_mem[c][w] = '0;
    endfunction

    // Response monitor: stability while stalled, and per-channel in-order scoreboard matching.
    always @(negedge clk) begin
        obs = {bus_if.rsp_chan_o, bus_if.rsp_write_o, bus_if.rsp_id_o, bus_if.rsp_rdata_o};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                n_cmp++;
                if (bus_if.rsp_valid_o !== 1'b1 || obs !== held) begin
                    n_err++;
                    $display("FAIL hold_stable: got valid=%b rsp=%h, required valid=1 rsp=%h",
                             bus_if.rsp_valid_o, obs, held);
                end
            end
            stalled = 1'b0;
            if (bus_if.rsp_valid_o === 1'b1) begin
                if (bus_if.rsp_ready_i !== 1'b1) begin
                    stalled = 1'b1;
                    held    = obs;
                end else begin
                    mon_idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (mon_idx < 0 && exp_q[i][EW-1:EW-2] == obs[EW-1:EW-2])
                            mon_idx = i;
                    n_cmp++;
                    if (mon_idx < 0) begin
                        n_err++;
                        $display("FAIL rsp_unexpected: got rsp=%h, required none pending on chan %0d",
                                 obs, obs[EW-1:EW-2]);
                    end else begin
                        if (exp_q[mon_idx] !== obs) begin
                            n_err++;
                            $display("FAIL rsp_payload: got %h, required %h", obs, exp_q[mon_idx]);
                        end
                        exp_q.delete(mon_idx);
                    end
                    grant_log.push_back(obs[EW-1:EW-2]);
                    n_rsp++;
                end
            end
        end
    end

    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [IW-1:0] id, output int t_acc);
        logic [DW-1:0] exp_d;
        int waited;
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = wr;
        bus_if.req_addr_i  = a;
        bus_if.req_wdata_i = d;
        bus_if.req_id_i    = id;
        t_acc  = -1;
        waited = 0;
        while (t_acc < 0 && waited < 200) begin
            @(negedge clk);
            if (bus_if.req_ready_o === 1'b1) t_acc = cyc + 1;
            @(posedge clk);
            #1;
            waited++;
        end
        bus_if.req_valid_i = 1'b0;
        n_cmp++;
        if (t_acc < 0) begin
            n_err++;
            $display("FAIL accept_timeout: got no accept for id %0d, required accept", id);
        end else begin
            if (wr) begin
                model_mem[chan_of(a)][word_of(a)] = d;
                exp_d = '0;
            end else begin
                exp_d = model_mem[chan_of(a)][word_of(a)];
            end
            exp_q.push_back({chan_of(a), wr, id, exp_d});
        end
    endtask

    task automatic wait_rsp(output int t_seen, output logic [1:0] ch);
        t_seen = -1;
        ch     = '0;
        for (int n = 0; n < 100 && t_seen < 0; n++) begin
            @(negedge clk);
            if (bus_if.rsp_valid_o === 1'b1) begin
                t_seen = cyc;
                ch     = bus_if.rsp_chan_o;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        ok = (exp_q.size() == 0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus_if.req_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_req_ready: got %b, required 0", bus_if.req_ready_o);
        end
        n_cmp++;
        if (bus_if.rsp_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_rsp_valid: got %b, required 0", bus_if.rsp_valid_o);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        n_cmp++;
        if ({bus_if.rsp_write_o, bus_if.rsp_id_o, bus_if.rsp_rdata_o, bus_if.rsp_chan_o} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp_fields: got %h, required 0",
                     {bus_if.rsp_write_o, bus_if.rsp_id_o, bus_if.rsp_rdata_o, bus_if.rsp_chan_o});
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        int t, ts;
        logic [1:0] ch;
        bit ok;
        bus_if.rsp_ready_i = 1'b1;
        send(1'b1, 48'h0, 64'hdead_beef_0123_4567, 4'd5, t);
        wait_rsp(ts, ch);
        n_cmp++;
        if (ts - t != LAT) begin
            n_err++;
            $display("FAIL write_ack_latency: got %0d, required %0d", ts - t, LAT);
        end
        wait_drain(ok);
        send(1'b0, 48'h0, '0, 4'd6, t);
        wait_rsp(ts, ch);
        n_cmp++;
        if (ts - t != LAT || ch !== 2'd0) begin
            n_err++;
            $display("FAIL read_latency_chan: got lat=%0d chan=%0d, required lat=%0d chan=0", ts - t, ch, LAT);
        end
        wait_drain(ok);
        n_cmp++;
        if (!ok || busy !== 1'b0) begin
            n_err++;
            $display("FAIL write_read_drain: got drained=%b busy=%b, required drained=1 busy=0", ok, busy);
        end
    endtask

    task automatic test_unwritten_read();
        int t, ts;
        logic [1:0] ch;
        bit ok;
        send(1'b0, 48'h3000, '0, 4'd3, t);
        wait_rsp(ts, ch);
        n_cmp++;
        if (ts - t != LAT || ch !== 2'd3) begin
            n_err++;
            $display("FAIL unwritten_lat_chan: got lat=%0d chan=%0d, required lat=%0d chan=3", ts - t, ch, LAT);
        end
        wait_drain(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL unwritten_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_round_robin();
        int t;
        bit ok;
        logic [7:0] got;
        logic [AW-1:0] r3_addr [3];
        for (int r = 0; r < 2; r++) begin
            bus_if.rsp_ready_i = 1'b0;
            grant_log.delete();
            for (int c = 0; c < NC; c++)
                send(1'b0, (AW'(c) << 12) | AW'(16), '0, IW'(c + 4 * r), t);
            wait_cycles(LAT + 4);
            bus_if.rsp_ready_i = 1'b1;
            wait_drain(ok);
            got = '0;
            for (int i = 0; i < grant_log.size(); i++) got = {got[5:0], grant_log[i]};
            n_cmp++;
            if (!ok || grant_log.size() != 4 || got !== 8'h1b) begin
                n_err++;
                $display("FAIL rr_round%0d: got order=%h n=%0d, required order=1b n=4", r + 1, got, grant_log.size());
            end
        end
        // Lock lands on ch1; the pointer then moves to 2, so ch3 must beat ch0.
        r3_addr[0] = 48'h1018;
        r3_addr[1] = 48'h0018;
        r3_addr[2] = 48'h3018;
        bus_if.rsp_ready_i = 1'b0;
        grant_log.delete();
        for (int i = 0; i < 3; i++) send(1'b0, r3_addr[i], '0, IW'(10 + i), t);
        wait_cycles(LAT + 4);
        bus_if.rsp_ready_i = 1'b1;
        wait_drain(ok);
        got = '0;
        for (int i = 0; i < grant_log.size(); i++) got = {got[5:0], grant_log[i]};
        n_cmp++;
        if (!ok || grant_log.size() != 3 || got !== 8'h1c) begin
            n_err++;
            $display("FAIL rr_rotate: got order=%h n=%0d, required order=1c n=3", got, grant_log.size());
        end
    endtask

    task automatic test_backpressure();
        int t, base;
        bit ok, leaked;
        base = n_rsp;
        bus_if.rsp_ready_i = 1'b0;
        for (int k = 0; k < MO; k++) send(1'b0, 48'h1000 + AW'(k * 8), '0, IW'(k), t);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = 48'h1040;
        bus_if.req_id_i    = 4'd8;
        leaked = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            if (bus_if.req_ready_o !== 1'b0) leaked = 1'b1;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (leaked) begin
            n_err++;
            $display("FAIL full_ready: got req_ready=1 with %0d in flight, required 0", MO);
        end
        bus_if.rsp_ready_i = 1'b1;
        send(1'b0, 48'h1040, '0, 4'd8, t);
        wait_drain(ok);
        n_cmp++;
        if (!ok || n_rsp - base != MO + 1) begin
            n_err++;
            $display("FAIL backpressure_count: got %0d responses, required %0d", n_rsp - base, MO + 1);
        end
    endtask

    task automatic test_ready_toggle();
        int base;
        bit ok;
        logic [AW-1:0] addrs [4];
        base = n_rsp;
        for (int k = 0; k < 4; k++)
            addrs[k] = (AW'($urandom_range(0, 3)) << 12) | AW'(8'h80 + k * 8);
        fork
            begin
                int t;
                for (int k = 0; k < 4; k++) send(1'b1, addrs[k], {$urandom, $urandom}, IW'(k), t);
                for (int k = 0; k < 4; k++) send(1'b0, addrs[k], '0, IW'(k + 4), t);
            end
            begin
                repeat (80) begin
                    bus_if.rsp_ready_i = ~bus_if.rsp_ready_i;
                    @(posedge clk);
                    #1;
                end
                bus_if.rsp_ready_i = 1'b1;
            end
        join
        wait_drain(ok);
        n_cmp++;
        if (!ok || n_rsp - base != 8) begin
            n_err++;
            $display("FAIL toggle_count: got %0d responses, required 8", n_rsp - base);
        end
    endtask

    task automatic test_reset_in_flight();
        int t, base;
        bit ok;
        bus_if.rsp_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) send(1'b0, (AW'(k % NC) << 12) | AW'(8'h28), '0, IW'(k), t);
        wait_cycles(LAT + 4);
        n_cmp++;
        if (bus_if.rsp_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_valid: got %b, required 1", bus_if.rsp_valid_o);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus_if.rsp_valid_o, bus_if.req_ready_o, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL async_reset: got valid/ready/busy=%b%b%b, required 000",
                     bus_if.rsp_valid_o, bus_if.req_ready_o, busy);
        end
        exp_q.delete();
        clear_model();
        base = n_rsp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus_if.rsp_ready_i = 1'b1;
        wait_cycles(LAT * 2);
        n_cmp++;
        if (n_rsp != base || busy !== 1'b0) begin
            n_err++;
            $display("FAIL stale_after_reset: got %0d responses busy=%b, required 0 busy=0", n_rsp - base, busy);
        end
        send(1'b0, 48'h0, '0, 4'd9, t);
        wait_drain(ok);
        n_cmp++;
        if (!ok || n_rsp != base + 1) begin
            n_err++;
            $display("FAIL post_reset_read: got %0d responses, required 1", n_rsp - base);
        end
    endtask

    initial begin
        bus_if.req_valid_i = 1'b0;
        bus_if.req_write_i = 1'b0;
        bus_if.req_addr_i  = '0;
        bus_if.req_wdata_i = '0;
        bus_if.req_id_i    = '0;
        bus_if.rsp_ready_i = 1'b0;
        clear_model();
        test_reset();
        test_write_read();
        test_unwritten_read();
        test_round_robin();
        test_backpressure();
        test_ready_toggle();
        test_reset_in_flight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
